// File: rtl/prog_loader.sv
// prog_loader: fills CPU program memory from a framed byte stream and holds the CPU in reset until a verified load.
// Optional build macro PROG_LOADER_ZERO_FILL_EN writes NOPs to the words above the loaded program.
module prog_loader #(
    parameter int         CMD_SIZE       = 19,
    parameter int         PROG_SIZE      = 32,
    parameter int         PROG_ADDR_SIZE = $clog2(PROG_SIZE),
    parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      prog_we,
    output logic [PROG_ADDR_SIZE-1:0] prog_addr,
    output logic [CMD_SIZE-1:0]       prog_wdata,
    output logic                      cpu_reset,
    output logic                      done,
    output logic                      err,
    output logic [PROG_ADDR_SIZE:0]   word_cnt
);

    localparam int CNT_W = PROG_ADDR_SIZE + 1;
    localparam int HI_W  = CMD_SIZE - 16;
    localparam logic [8:0]                N_MAX     = 9'(PROG_SIZE);
    localparam logic [PROG_ADDR_SIZE-1:0] ADDR_LAST = PROG_ADDR_SIZE'(PROG_SIZE - 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_COUNT = 4'd1,
        S_B0    = 4'd2,
        S_B1    = 4'd3,
        S_B2    = 4'd4,
        S_WRITE = 4'd5,
        S_CSUM  = 4'd6,
        S_DONE  = 4'd7,
`ifdef PROG_LOADER_ZERO_FILL_EN
        S_FILL  = 4'd9,
`endif
        S_ERR   = 4'd8
    } state_t;

    state_t                    r_state;
    logic                      r_prog_we;
    logic [PROG_ADDR_SIZE-1:0] r_prog_addr;
    logic [CMD_SIZE-1:0]       r_prog_wdata;
    logic                      r_cpu_reset;
    logic                      r_done;
    logic                      r_err;
    logic [CNT_W-1:0]          r_word_cnt;
    logic [CNT_W-1:0]          r_n;
    logic [HI_W-1:0]           r_b0;
    logic [7:0]                r_b1;
    logic [7:0]                r_xor;

    logic                      w_in_ready;
    logic                      w_accept;
    logic                      w_is_sync;
    logic                      w_b0_ok;
    logic                      w_n_bad;
    logic [CNT_W-1:0]          w_cnt_next;

    function automatic logic [7:0] f_csum_next(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

    assign w_accept   = in_valid && w_in_ready;
    assign w_is_sync  = (in_data == SYNC_BYTE);
    assign w_b0_ok    = ((in_data >> HI_W) == 8'd0);
    assign w_n_bad    = (in_data == 8'd0) || ({1'b0, in_data} > N_MAX);
    assign w_cnt_next = r_word_cnt + CNT_W'(1);

    // Byte acceptance decoded from the current state.
    always_comb begin
        w_in_ready = 1'b1;
        case (r_state)
            S_WRITE: w_in_ready = 1'b0;
`ifdef PROG_LOADER_ZERO_FILL_EN
            S_FILL:  w_in_ready = 1'b0;
`endif
            default: w_in_ready = 1'b1;
        endcase
    end

    // Frame parser, command assembly and registered memory/status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_prog_we    <= 1'b0;
            r_prog_addr  <= '0;
            r_prog_wdata <= '0;
            r_cpu_reset  <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_word_cnt   <= '0;
            r_n          <= '0;
            r_b0         <= '0;
            r_b1         <= 8'd0;
            r_xor        <= 8'd0;
        end else begin
            r_prog_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_is_sync) begin
                        r_state <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (w_accept) begin
                        if (w_n_bad) begin
                            r_state     <= S_ERR;
                            r_err       <= 1'b1;
                            r_done      <= 1'b0;
                            r_cpu_reset <= 1'b1;
                        end else begin
                            r_n         <= CNT_W'(in_data);
                            r_word_cnt  <= '0;
                            r_prog_addr <= '0;
                            r_xor       <= 8'd0;
                            r_state     <= S_B0;
                        end
                    end
                end
                S_B0: begin
                    if (w_accept) begin
                        if (!w_b0_ok) begin
                            r_state     <= S_ERR;
                            r_err       <= 1'b1;
                            r_done      <= 1'b0;
                            r_cpu_reset <= 1'b1;
                        end else begin
                            r_b0    <= in_data[HI_W-1:0];
                            r_xor   <= f_csum_next(r_xor, in_data);
                            r_state <= S_B1;
                        end
                    end
                end
                S_B1: begin
                    if (w_accept) begin
                        r_b1    <= in_data;
                        r_xor   <= f_csum_next(r_xor, in_data);
                        r_state <= S_B2;
                    end
                end
                S_B2: begin
                    if (w_accept) begin
                        r_prog_wdata <= {r_b0, r_b1, in_data};
                        r_prog_we    <= 1'b1;
                        r_xor        <= f_csum_next(r_xor, in_data);
                        r_state      <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_word_cnt <= w_cnt_next;
                    // The address pins at the last word rather than wrapping onto word 0.
                    if (r_prog_addr != ADDR_LAST) begin
                        r_prog_addr <= r_prog_addr + PROG_ADDR_SIZE'(1);
                    end
                    if (w_cnt_next == r_n) begin
                        r_state <= S_CSUM;
                    end else begin
                        r_state <= S_B0;
                    end
                end
                S_CSUM: begin
                    if (w_accept) begin
                        if (in_data == r_xor) begin
`ifdef PROG_LOADER_ZERO_FILL_EN
                            if (r_n == CNT_W'(PROG_SIZE)) begin
                                r_state     <= S_DONE;
                                r_cpu_reset <= 1'b0;
                                r_done      <= 1'b1;
                                r_err       <= 1'b0;
                            end else begin
                                r_state      <= S_FILL;
                                r_prog_we    <= 1'b1;
                                r_prog_wdata <= '0;
                            end
`else
                            r_state     <= S_DONE;
                            r_cpu_reset <= 1'b0;
                            r_done      <= 1'b1;
                            r_err       <= 1'b0;
`endif
                        end else begin
                            r_state     <= S_ERR;
                            r_err       <= 1'b1;
                            r_done      <= 1'b0;
                            r_cpu_reset <= 1'b1;
                        end
                    end
                end
`ifdef PROG_LOADER_ZERO_FILL_EN
                S_FILL: begin
                    if (r_prog_addr == ADDR_LAST) begin
                        r_state     <= S_DONE;
                        r_cpu_reset <= 1'b0;
                        r_done      <= 1'b1;
                        r_err       <= 1'b0;
                    end else begin
                        r_prog_addr <= r_prog_addr + PROG_ADDR_SIZE'(1);
                        r_prog_we   <= 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    if (w_accept && w_is_sync) begin
                        r_state     <= S_COUNT;
                        r_cpu_reset <= 1'b1;
                        r_done      <= 1'b0;
                    end
                end
                S_ERR: begin
                    if (w_accept && w_is_sync) begin
                        r_state <= S_COUNT;
                        r_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign prog_we    = r_prog_we;
    assign prog_addr  = r_prog_addr;
    assign prog_wdata = r_prog_wdata;
    assign cpu_reset  = r_cpu_reset;
    assign done       = r_done;
    assign err        = r_err;
    assign word_cnt   = r_word_cnt;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: frame table plus hand-written reset/boundary sequences,
// with expected memory writes held in a scoreboard queue.
module tb_prog_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        prog_we;
    logic [4:0]  prog_addr;
    logic [18:0] prog_wdata;
    logic        cpu_reset;
    logic        done;
    logic        err;
    logic [5:0]  word_cnt;

    int checks = 0;
    int errors = 0;
    int gap    = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [18:0] data;
    } wr_t;

    typedef struct {
        int              nb;
        logic [95:0]     b;
        int              nw;
        logic [1:0][4:0] wa;
        logic [1:0][18:0] wd;
        logic            dn;
        logic            er;
        logic            cr;
        logic [5:0]      wc;
    } vec_t;

    wr_t  exp_q[$];
    vec_t tbl[8];

    prog_loader dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .err        (err),
        .word_cnt   (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int nb, input logic [95:0] b, input int nw,
                                input logic [4:0] a0, input logic [18:0] d0,
                                input logic [4:0] a1, input logic [18:0] d1,
                                input logic dn, input logic er, input logic cr, input logic [5:0] wc);
        vec_t v;
        v.nb = nb; v.b = b; v.nw = nw;
        v.wa[0] = a0; v.wd[0] = d0; v.wa[1] = a1; v.wd[1] = d1;
        v.dn = dn; v.er = er; v.cr = cr; v.wc = wc;
        return v;
    endfunction

    // Drive one byte and return 1ns after the edge that transfers it.
    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got in_ready=%0b expected 1 within 40 cycles", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic push_wr(input logic [4:0] a, input logic [18:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic chk_status(input string tag, input logic dn, input logic er, input logic cr, input logic [5:0] wc);
        chk({tag, "_done"}, 32'(done), 32'(dn));
        chk({tag, "_err"}, 32'(err), 32'(er));
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(cr));
        chk({tag, "_word_cnt"}, 32'(word_cnt), 32'(wc));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        for (int k = 0; k < v.nw; k++) push_wr(v.wa[k], v.wd[k]);
        for (int k = 0; k < v.nb; k++) send_byte(v.b[95 - 8 * k -: 8]);
        chk_status($sformatf("vec%0d", idx), v.dn, v.er, v.cr, v.wc);
    endtask

    // Scoreboard: every write strobe must match the next expected write.
    always @(negedge clk) begin
        if (reset && prog_we) begin
            chk("write_in_ready_low", 32'(in_ready), 32'd0);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h expected no write", prog_addr, prog_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (prog_addr !== e.addr || prog_wdata !== e.data) begin
                    errors++;
                    $display("FAIL write: got addr=0x%0h data=0x%0h expected addr=0x%0h data=0x%0h",
                             prog_addr, prog_wdata, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit expired expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [18:0] cmd;
        logic [7:0]  x;

        tbl[0] = mk(9, {8'hA5, 8'h02, 8'h01, 8'h23, 8'h45, 8'h07, 8'hFF, 8'hFF, 8'h60, 24'h0}, 2,
                    5'd0, 19'h12345, 5'd1, 19'h7FFFF, 1'b1, 1'b0, 1'b0, 6'd2);
        tbl[1] = mk(9, {8'hA5, 8'h02, 8'h01, 8'h23, 8'h45, 8'h07, 8'hFF, 8'hFF, 8'h61, 24'h0}, 2,
                    5'd0, 19'h12345, 5'd1, 19'h7FFFF, 1'b0, 1'b1, 1'b1, 6'd2);
        tbl[2] = tbl[0];
        tbl[3] = mk(6, {8'hA5, 8'h01, 8'h05, 8'hA5, 8'hA5, 8'h05, 48'h0}, 1,
                    5'd0, 19'h5A5A5, 5'd0, 19'h0, 1'b1, 1'b0, 1'b0, 6'd1);
        tbl[4] = mk(5, {8'hA5, 8'h01, 8'h08, 8'h00, 8'h00, 56'h0}, 0,
                    5'd0, 19'h0, 5'd0, 19'h0, 1'b0, 1'b1, 1'b1, 6'd0);
        tbl[5] = mk(2, {8'hA5, 8'h00, 80'h0}, 0,
                    5'd0, 19'h0, 5'd0, 19'h0, 1'b0, 1'b1, 1'b1, 6'd0);
        tbl[6] = mk(2, {8'hA5, 8'h21, 80'h0}, 0,
                    5'd0, 19'h0, 5'd0, 19'h0, 1'b0, 1'b1, 1'b1, 6'd0);
        tbl[7] = mk(6, {8'hA5, 8'h01, 8'h07, 8'h00, 8'h01, 8'h06, 48'h0}, 1,
                    5'd0, 19'h70001, 5'd0, 19'h0, 1'b1, 1'b0, 1'b0, 6'd1);

        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_prog_we", 32'(prog_we), 32'd0);
        chk("rst_prog_addr", 32'(prog_addr), 32'd0);
        chk("rst_prog_wdata", 32'(prog_wdata), 32'd0);
        chk_status("rst", 1'b0, 1'b0, 1'b1, 6'd0);
        reset = 1'b1;

        send_byte(8'h3C);
        send_byte(8'h11);
        chk_status("idle_junk", 1'b0, 1'b0, 1'b1, 6'd0);

        for (int i = 0; i < 8; i++) begin
            gap = i % 3;
            run_vec(tbl[i], i);
        end
        gap = 0;

        send_byte(8'h3C);
        send_byte(8'h00);
        chk_status("done_junk", 1'b1, 1'b0, 1'b0, 6'd1);

        // Full-size frame: leaving DONE re-asserts cpu_reset, address pins at 31.
        send_byte(8'hA5);
        chk("restart_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("restart_done", 32'(done), 32'd0);
        send_byte(8'h20);
        x = 8'h00;
        for (int k = 0; k < 32; k++) begin
            cmd = 19'(k) * 19'd12345 + 19'd7;
            push_wr(5'(k), cmd);
            send_byte({5'b0, cmd[18:16]});
            send_byte(cmd[15:8]);
            send_byte(cmd[7:0]);
            x = x ^ {5'b0, cmd[18:16]} ^ cmd[15:8] ^ cmd[7:0];
        end
        send_byte(x);
        chk_status("full", 1'b1, 1'b0, 1'b0, 6'd32);
        chk("full_addr_sat", 32'(prog_addr), 32'd31);

        // Asynchronous reset inside B1 of the second command.
        push_wr(5'd0, 19'h12345);
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h01);
        send_byte(8'h23);
        send_byte(8'h45);
        send_byte(8'h07);
        chk("b1_word_cnt", 32'(word_cnt), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_prog_we", 32'(prog_we), 32'd0);
        chk("arst_prog_addr", 32'(prog_addr), 32'd0);
        chk("arst_prog_wdata", 32'(prog_wdata), 32'd0);
        chk_status("arst", 1'b0, 1'b0, 1'b1, 6'd0);
        @(negedge clk);
        reset = 1'b1;
        run_vec(tbl[0], 20);

        // Asynchronous reset while the write strobe is high.
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h12);
        send_byte(8'h34);
        chk("wr_pulse_before_rst", 32'(prog_we), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_we_drop", 32'(prog_we), 32'd0);
        chk("arst_we_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        run_vec(tbl[3], 21);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
